param_bus_datapath: RTL
=======================

# param_bus_datapath

Parametrised single-bus register-transfer datapath: NREGS general registers of WIDTH bits, Y, double-width Z, HI/LO and in/out ports, all sharing one internal bus. It runs one ALU/transfer command per 4-cycle slot under a valid/ready command handshake. It sits between the control unit, which issues decoded commands, and the port pins. It is the generalised successor of the fixed 32-bit/16-register CPU datapath.

## Interface
- WIDTH, 32, data width; even, ≥8.
- NREGS, 16, general register count; power of two, ≥2.
- AW, $clog2(NREGS), register index width (derived, do not override).
- clk  in  1  clock, rising edge.
- clr  in  1  reset; one clock, asynchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  datapath idle, command accepted when cmd_valid && cmd_ready.
- cmd_op  in  4  opcode (see Operation).
- cmd_ra / cmd_rb / cmd_rc  in  AW each  destination, operand A source, operand B source.
- cmd_imm  in  WIDTH  immediate.
- cmd_use_imm  in  1  operand B = cmd_imm instead of R[rc].
- cmd_ba  in  1  base-address mode: R[0] read as zero for operand A.
- in_port  in  WIDTH  external input, sampled every cycle.
- out_port  out  WIDTH  output register.
- rsp_valid  out  1  high for exactly the T3 cycle of each command.
- rsp_result  out  WIDTH  Z low half; valid while rsp_valid.
- rsp_err  out  1  command illegal; valid while rsp_valid.
- hi_out / lo_out  out  WIDTH  HI / LO registers.
- bus_dbg  out  WIDTH  current bus value.

## Operation
- Opcodes: 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 SHR (logical), 5 SHRA, 6 SHL, 7 ROR, 8 ROL, 9 NEG (−B), 10 NOT (~B), 11 MUL, 12 MFHI, 13 MFLO, 14 IN, 15 OUT.
- Operand A = R[rb], or 0 when cmd_ba && rb==0. Operand B = cmd_imm if cmd_use_imm, else R[rc].
- Shift/rotate amount = B[$clog2(WIDTH)-1:0]. Shifting by 0 leaves A unchanged.
- All arithmetic wraps modulo 2^WIDTH. Z high half is 0 for every op except MUL.
- Command fields are captured in internal registers at acceptance. Inputs may change afterwards.
- FSM: IDLE → T1 → T2 → T3 → IDLE, unconditional after acceptance.
  - IDLE: bus = 0; cmd_ready = 1.
  - T1: bus = operand A; Y ← bus.
  - T2: bus = operand B, or HI (MFHI), LO (MFLO), or in_port (IN). Z ← f(Y, bus); transfer ops load Z = {0, bus}.
  - T3: bus = Z low half; rsp_valid = 1.
- Writeback at the end of T3:
  - R[ra] ← bus for all ops except MUL and OUT.
  - MUL: {HI, LO} ← Z; R[ra] unchanged.
  - OUT: out_port ← bus; no register write.
- Writes to R[0] are allowed. cmd_ba only affects reads.
- ra equal to rb or rc is legal, because operands are read before writeback.

## Timing
- Reset (clr low) forces, immediately and asynchronously:
  - all registers, Y, Z, HI, LO and out_port to 0;
  - FSM to IDLE;
  - cmd_ready = 0 while clr is low;
  - rsp_valid = 0, rsp_err = 0, rsp_result = 0, bus_dbg = 0.
- A command in flight when clr falls is discarded: no writeback, no response.
- Accept at edge k → T1 in cycle k+1, T2 in k+2, T3 (rsp_valid) in k+3, writeback at edge k+4.
- cmd_ready is high again in cycle k+4. Maximum throughput is one command per 4 cycles.
- cmd_ready and rsp_valid decode directly from the state register, with no combinational path from cmd_valid.
- A new command's T1 read sees the previous command's writeback.
- in_port is sampled at the end of T2 (IN). HI/LO are read in T2, so they reflect a MUL that has already completed.

## Configuration
- PARAM_BUS_DATAPATH_MUL_EN defined:
  - MUL computes the signed WIDTH×WIDTH product into 2·WIDTH-bit Z.
  - rsp_result = low half; rsp_err = 0.
- Undefined:
  - no multiplier is synthesised;
  - opcode 11 still takes 4 cycles with rsp_err = 1 and rsp_result = 0;
  - HI, LO and registers are unchanged.
- rsp_err is 0 for every other opcode in both builds.

## Test plan
- Reset mid-command: accept ADD, drop clr in T2 → no rsp_valid; every register reads 0 afterwards; cmd_ready = 1 one cycle after clr rises.
- R1=5, R2=7, ADD ra=3 rb=1 rc=2 → rsp_valid exactly 3 cycles after accept, rsp_result=12, R3=12; SUB → 0xFFFFFFFE.
- cmd_ba=1, rb=0, R0=0x100, imm=4, use_imm, ADD ra=4 → R4=4. With cmd_ba=0 → R4=0x104.
- R1=0x80000001, imm=1: ROR → 0xC0000000, SHRA → 0xC0000000, SHR → 0x40000000, SHL → 0x00000002.
- MUL_EN build: R1=−3, R2=0x40000000, MUL then MFHI ra=5, MFLO ra=6 → R5=0xFFFFFFFF, R6=0x40000000. Non-MUL build: rsp_err=1, HI/LO stay 0.
- WIDTH=16, NREGS=4: in_port=0xBEEF, IN ra=3, OUT rc=3 → out_port=0xBEEF. Back-to-back cmd_valid held high → accepts spaced exactly 4 cycles.

Source files
------------

// File: rtl/param_bus_datapath.sv
// Single-bus register-transfer datapath; one command per 4-cycle slot.
// Define PARAM_BUS_DATAPATH_MUL_EN to build the signed multiplier (op 11).
module param_bus_datapath #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [AW-1:0]    cmd_ra,
  input  logic [AW-1:0]    cmd_rb,
  input  logic [AW-1:0]    cmd_rc,
  input  logic [WIDTH-1:0] cmd_imm,
  input  logic             cmd_use_imm,
  input  logic             cmd_ba,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_err,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] bus_dbg
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SHR  = 4'd4;
  localparam logic [3:0] OP_SHRA = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_ROR  = 4'd7;
  localparam logic [3:0] OP_ROL  = 4'd8;
  localparam logic [3:0] OP_NEG  = 4'd9;
  localparam logic [3:0] OP_NOT  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_MFHI = 4'd12;
  localparam logic [3:0] OP_MFLO = 4'd13;
  localparam logic [3:0] OP_IN   = 4'd14;
  localparam logic [3:0] OP_OUT  = 4'd15;

  typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

  state_t state_q, state_d;
  logic   live_q;
  logic   accept;

  logic [3:0]       op_q;
  logic [AW-1:0]    ra_q, rb_q, rc_q;
  logic [WIDTH-1:0] imm_q;
  logic             use_imm_q, ba_q;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] y_q, z_lo_q, hi_q, lo_q, out_q;
`ifdef PARAM_BUS_DATAPATH_MUL_EN
  logic [WIDTH-1:0]   z_hi_q;
  logic [2*WIDTH-1:0] prod;
`endif

  logic [WIDTH-1:0] op_a, op_b, bus, alu;
  logic [SW-1:0]    sh;
  int unsigned      rot;

  // live_q holds ready low until the first edge after clr releases
  assign cmd_ready  = live_q && (state_q == IDLE);
  assign accept     = cmd_valid && cmd_ready;
  assign rsp_valid  = (state_q == T3);
  assign rsp_result = rsp_valid ? z_lo_q : '0;
`ifdef PARAM_BUS_DATAPATH_MUL_EN
  assign rsp_err    = 1'b0;
`else
  assign rsp_err    = rsp_valid && (op_q == OP_MUL);
`endif
  assign out_port   = out_q;
  assign hi_out     = hi_q;
  assign lo_out     = lo_q;
  assign bus_dbg    = bus;

  assign op_a = (ba_q && rb_q == '0) ? '0 : regs_q[rb_q];
  assign op_b = use_imm_q ? imm_q : regs_q[rc_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = T1;
      T1:      state_d = T2;
      T2:      state_d = T3;
      T3:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus = '0;
    case (state_q)
      T1: bus = op_a;
      T2: begin
        unique case (1'b1)
          op_q == OP_MFHI: bus = hi_q;
          op_q == OP_MFLO: bus = lo_q;
          op_q == OP_IN:   bus = in_port;
          default:         bus = op_b;
        endcase
      end
      T3:      bus = z_lo_q;
      default: bus = '0;
    endcase
  end

  always_comb begin
    sh  = bus[SW-1:0];
    rot = 32'(sh) % WIDTH;
    alu = bus;
    case (op_q)
      OP_ADD:  alu = y_q + bus;
      OP_SUB:  alu = y_q - bus;
      OP_AND:  alu = y_q & bus;
      OP_OR:   alu = y_q | bus;
      OP_SHR:  alu = y_q >> sh;
      OP_SHRA: alu = $signed(y_q) >>> sh;
      OP_SHL:  alu = y_q << sh;
      OP_ROR:  alu = (y_q >> rot) | (y_q << (WIDTH - rot));
      OP_ROL:  alu = (y_q << rot) | (y_q >> (WIDTH - rot));
      OP_NEG:  alu = '0 - bus;
      OP_NOT:  alu = ~bus;
      default: alu = bus;
    endcase
  end

`ifdef PARAM_BUS_DATAPATH_MUL_EN
  // sign-extended unsigned multiply yields the exact signed product
  assign prod = {{WIDTH{y_q[WIDTH-1]}}, y_q} * {{WIDTH{bus[WIDTH-1]}}, bus};
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= IDLE;
      live_q    <= 1'b0;
      op_q      <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      rc_q      <= '0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      ba_q      <= 1'b0;
      y_q       <= '0;
      z_lo_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      out_q     <= '0;
`ifdef PARAM_BUS_DATAPATH_MUL_EN
      z_hi_q    <= '0;
`endif
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q      <= cmd_op;
            ra_q      <= cmd_ra;
            rb_q      <= cmd_rb;
            rc_q      <= cmd_rc;
            imm_q     <= cmd_imm;
            use_imm_q <= cmd_use_imm;
            ba_q      <= cmd_ba;
          end
        end
        T1: y_q <= bus;
        T2: begin
`ifdef PARAM_BUS_DATAPATH_MUL_EN
          z_lo_q <= (op_q == OP_MUL) ? prod[WIDTH-1:0] : alu;
          z_hi_q <= (op_q == OP_MUL) ? prod[2*WIDTH-1:WIDTH] : '0;
`else
          z_lo_q <= (op_q == OP_MUL) ? '0 : alu;
`endif
        end
        T3: begin
          unique case (1'b1)
            op_q == OP_OUT: out_q <= bus;
            op_q == OP_MUL: begin
`ifdef PARAM_BUS_DATAPATH_MUL_EN
              hi_q <= z_hi_q;
              lo_q <= z_lo_q;
`endif
            end
            default: regs_q[ra_q] <= bus;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
